// File: rtl/fifo_chk_pkg.sv
// Shared sizing helpers and counter types for the checked synchronous FIFO.
package fifo_chk_pkg;

    localparam int unsigned ERR_W_DEF = 16;

    typedef logic [ERR_W_DEF-1:0] err_cnt_t;

    function automatic int unsigned calc_aw(input int unsigned depth);
        int unsigned aw;
        aw = 0;
        while ((32'd1 << aw) < depth) aw++;
        return aw;
    endfunction

    // All-ones value a w-bit saturating counter stops at (w up to 64).
    function automatic logic [63:0] sat_of(input int unsigned w);
        return (64'd1 << w) - 64'd1;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter: increments on inc, holds at all-ones, async reset.
module sat_counter
    import fifo_chk_pkg::*;
#(
    parameter int unsigned W = ERR_W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] q
);

    localparam logic [W-1:0] SAT = W'(sat_of(W));

    logic [W-1:0] r_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= '0;
        end else if (inc && (r_q != SAT)) begin
            r_q <= r_q + {{(W-1){1'b0}}, 1'b1};
        end
    end

    assign q = r_q;

endmodule

// File: rtl/sync_fifo_chk.sv
// Single-clock FIFO with wrap-bit pointers, registered read data and
// saturating overflow/underflow counters plus a sticky error flag.
module sync_fifo_chk
    import fifo_chk_pkg::*;
#(
    parameter  int unsigned WIDTH = 8,
    parameter  int unsigned DEPTH = 8,
    parameter  int unsigned ERR_W = ERR_W_DEF,
    localparam int unsigned AW    = calc_aw(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             full,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    output logic             empty,
    output logic [AW:0]      count,
    output logic [ERR_W-1:0] ovf_cnt,
    output logic [ERR_W-1:0] udf_cnt,
    output logic             err
);

    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rd_data;
    logic             r_rd_valid;
    logic             r_err;

    logic w_full;
    logic w_empty;
    logic w_wr_ok;
    logic w_rd_ok;
    logic w_ovf;
    logic w_udf;

    // Equal indices: the wrap bit distinguishes full from empty.
    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[AW] != r_rptr[AW]) &&
                     (r_wptr[AW-1:0] == r_rptr[AW-1:0]);

    assign w_wr_ok = wr_en && !w_full;
    assign w_rd_ok = rd_en && !w_empty;
    assign w_ovf   = wr_en && w_full;
    assign w_udf   = rd_en && w_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_wr_ok) r_wptr <= r_wptr + {{AW{1'b0}}, 1'b1};
            if (w_rd_ok) r_rptr <= r_rptr + {{AW{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_ok) r_mem[r_wptr[AW-1:0]] <= wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_ok;
            if (w_rd_ok) r_rd_data <= r_mem[r_rptr[AW-1:0]];
            if (w_ovf || w_udf) r_err <= 1'b1;
        end
    end

    sat_counter #(.W(ERR_W)) u_ovf_cnt (
        .clk (clk),
        .rst (rst),
        .inc (w_ovf),
        .q   (ovf_cnt)
    );

    sat_counter #(.W(ERR_W)) u_udf_cnt (
        .clk (clk),
        .rst (rst),
        .inc (w_udf),
        .q   (udf_cnt)
    );

    assign full     = w_full;
    assign empty    = w_empty;
    assign count    = r_wptr - r_rptr;
    assign rd_data  = r_rd_data;
    assign rd_valid = r_rd_valid;
    assign err      = r_err;

endmodule
